core_gpio: RTL and testbench
============================

CORE_GPIO -- requirements
Module: core_gpio

Interface
REQ-001 IO_NUM, default 32, number of GPIO bits (1..32).
REQ-002 APB_WIDTH, default 32, APB data width (8, 16 or 32).
REQ-003 OE_TYPE, default 0; 0 = GPIO_OE from CONFIG bit2, 1 = GPIO_OE held all ones.
REQ-004 INT_BUS, default 1; 1 = INT_OR driven, 0 = INT_OR held 0.
REQ-005 PCLK  in  1  sole clock, all state on rising edge.
REQ-006 PRESETN  in  1  reset, asynchronous, active-low.
REQ-007 PSEL  in  1  APB select.
REQ-008 PENABLE  in  1  APB access phase.
REQ-009 PWRITE  in  1  1 = write, 0 = read.
REQ-010 PADDR  in  8  byte address.
REQ-011 PWDATA  in  APB_WIDTH  write data.
REQ-012 PRDATA  out  APB_WIDTH  read data.
REQ-013 PREADY  out  1  tied 1 (zero wait states).
REQ-014 PSLVERR  out  1  tied 0.
REQ-015 GPIO_IN  in  IO_NUM  asynchronous pin inputs.
REQ-016 GPIO_OUT  out  IO_NUM  pin output values.
REQ-017 GPIO_OE  out  IO_NUM  pin output enables, 1 = drive.
REQ-018 INT  out  IO_NUM  per-bit interrupt, active-high.
REQ-019 INT_OR  out  1  OR of all INT bits.

Function
REQ-020 Write commits on a PCLK edge with PSEL=PENABLE=PWRITE=1; PRDATA is combinational from PADDR while PSEL=1 and PWRITE=0, otherwise 0.
REQ-021 Register map: CONFIG_i at 0x00+4*i (i<IO_NUM, 8 bits); INTR at 0x80; GPIN at 0x90; GPOUT at 0xA0.
REQ-022 For APB_WIDTH 8/16, INTR/GPIN/GPOUT split into APB_WIDTH slices; slice k at base+4*k.
REQ-023 CONFIG bits: bit0 output enable, bit2 output-buffer enable, bit3 interrupt enable, bits7:5 int type (0 level-high, 1 level-low, 2 rising, 3 falling, 4 both edges, 5-7 no interrupt); bits 1 and 4 are read/write with no effect.
REQ-024 Unmapped addresses, CONFIG_i with i>=IO_NUM, and bits >=IO_NUM read 0; writes to them are ignored.
REQ-025 GPIO_IN passes a 2-flop synchronizer (s1, s2); GPIN reads s2, so a pin change is readable after the 2nd rising edge.
REQ-026 Edge detect compares s2 with a third flop s3 (previous s2).
REQ-027 Interrupt flag INTR[i] is registered.
REQ-028 Edge types: INTR[i] sets on the selected edge, i.e. at the 3rd rising edge after the pin change.
REQ-029 Edge types: INTR[i] clears only by writing 1 to that INTR bit; writing 0 has no effect.
REQ-030 Edge types: a set and a clear in the same cycle leave INTR[i]=1 (set wins).
REQ-031 Level types: INTR[i] follows the active level of s2 with one cycle delay; a write-1 clear has no lasting effect while the level is active.
REQ-032 Flags update only when CONFIG_i bit3=1; when bit3=0 INTR[i] is held 0.
REQ-033 INT[i] = INTR[i]; INT_OR = |INT when INT_BUS=1, else 0.
REQ-034 GPIO_OUT[i] = GPOUT[i] when CONFIG_i bit0=1, else 0; GPIO_OE[i] = CONFIG_i bit2 (OE_TYPE=0).
REQ-035 Changing interrupt type or enable resets s3 comparison nothing: no spurious edge is generated by a config write alone.

Reset
REQ-036 PRESETN low asynchronously clears all CONFIG, GPOUT, INTR and s1/s2/s3 to 0, giving GPIO_OUT=0, GPIO_OE=0 (OE_TYPE=0), INT=0, INT_OR=0, PRDATA=0; mid-transfer resets abort the write.

Verification
REQ-037 Reset, then read CONFIG_0, INTR, GPIN, GPOUT -> all 0; PREADY=1, PSLVERR=0.
REQ-038 Write CONFIG_0=0x05, GPOUT=0x1 -> GPIO_OUT[0]=1, GPIO_OE[0]=1; CONFIG_0=0x04 -> GPIO_OUT[0]=0.
REQ-039 GPIO_IN=0xA5 (IO_NUM=8) -> GPIN reads 0x00 after 1 edge, 0xA5 after 2 edges.
REQ-040 CONFIG_1=0x48 (rising), raise GPIO_IN[1] -> INT[1]=INT_OR=1 at 3rd edge; write INTR=0x2 -> INT[1]=0; pin stays high -> remains 0.
REQ-041 CONFIG_2=0x08 (level-high), GPIO_IN[2]=1 -> INT[2]=1; write INTR=0x4 -> stays 1; drop pin -> INT[2]=0.
REQ-042 Edge on GPIO_IN[1] in the cycle INTR bit1 is written 1 -> INTR[1] stays 1.

Source files
------------

// File: rtl/core_gpio_if.sv
// core_gpio_if: APB slave bus bundle for core_gpio.
//   master modport: drives PSEL, PENABLE, PWRITE, PADDR, PWDATA;
//                   receives PRDATA, PREADY, PSLVERR.
//   slave modport : the mirror image, used by core_gpio.
interface core_gpio_if #(
   parameter int APB_WIDTH = 32
);
   logic                 PSEL;
   logic                 PENABLE;
   logic                 PWRITE;
   logic [7:0]           PADDR;
   logic [APB_WIDTH-1:0] PWDATA;
   logic [APB_WIDTH-1:0] PRDATA;
   logic                 PREADY;
   logic                 PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/core_gpio.sv
// core_gpio: APB-programmable GPIO block with per-bit configuration,
// 2-flop input synchronizer, edge/level interrupts and an OR'd interrupt.
//   PCLK     : sole clock, rising edge
//   PRESETN  : asynchronous active-low reset
//   apb      : APB slave bus (zero wait states, never errors)
//   GPIO_IN  : asynchronous pin inputs
//   GPIO_OUT : pin output values (gated by CONFIG bit0)
//   GPIO_OE  : pin output enables (CONFIG bit2, or all ones when OE_TYPE=1)
//   INT      : per-bit interrupt flags
//   INT_OR   : OR of INT (held 0 when INT_BUS=0)
// Register map: CONFIG_i @ 4*i, INTR @ 0x80, GPIN @ 0x90, GPOUT @ 0xA0;
// the 32-bit registers are split into APB_WIDTH slices at base+4*k.
module core_gpio #(
   parameter int IO_NUM    = 32,
   parameter int APB_WIDTH = 32,
   parameter int OE_TYPE   = 0,
   parameter int INT_BUS   = 1
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   core_gpio_if.slave        apb,
   input  logic [IO_NUM-1:0] GPIO_IN,
   output logic [IO_NUM-1:0] GPIO_OUT,
   output logic [IO_NUM-1:0] GPIO_OE,
   output logic [IO_NUM-1:0] INT,
   output logic              INT_OR
);
   localparam int NUM_SLICES = 32 / APB_WIDTH;

   logic [IO_NUM*8-1:0] cfg_reg, cfg_next;
   logic [IO_NUM-1:0]   gpout_reg, gpout_next;
   logic [IO_NUM-1:0]   intr_reg, intr_next;
   logic [IO_NUM-1:0]   s1_reg, s2_reg, s3_reg;

   logic       wr_en, aligned, slice_ok;
   logic       is_cfg, is_intr, is_gpin, is_gpout;
   logic [4:0] cfg_idx;
   logic [1:0] slice;

   // ---------------- address decode ----------------
   assign wr_en    = apb.PSEL & apb.PENABLE & apb.PWRITE;
   assign aligned  = (apb.PADDR[1:0] == 2'b00);
   assign cfg_idx  = apb.PADDR[6:2];
   assign slice    = apb.PADDR[3:2];
   assign is_cfg   = aligned && !apb.PADDR[7] && (32'(cfg_idx) < IO_NUM);
   // Only as many slices exist as are needed to cover 32 bits.
   assign slice_ok = aligned && (32'(slice) < NUM_SLICES);
   assign is_intr  = slice_ok && (apb.PADDR[7:4] == 4'h8);
   assign is_gpin  = slice_ok && (apb.PADDR[7:4] == 4'h9);
   assign is_gpout = slice_ok && (apb.PADDR[7:4] == 4'hA);

   // ---------------- read path (combinational) ----------------
   logic [7:0]  cfg_rd;
   logic [31:0] word_rd, word_shift;
   logic [APB_WIDTH-1:0] rd_data;

   always_comb begin
      cfg_rd = 8'h00;
      for (int i = 0; i < IO_NUM; i++) begin
         if (cfg_idx == 5'(i)) cfg_rd = cfg_reg[i*8 +: 8];
      end
      word_rd = 32'h0;
      if (is_intr)       word_rd = 32'(intr_reg);
      else if (is_gpin)  word_rd = 32'(s2_reg);
      else if (is_gpout) word_rd = 32'(gpout_reg);
      word_shift = word_rd >> (32'(slice) * APB_WIDTH);
      rd_data    = is_cfg ? APB_WIDTH'(cfg_rd) : word_shift[APB_WIDTH-1:0];
   end

   assign apb.PRDATA  = (apb.PSEL && !apb.PWRITE) ? rd_data : '0;
   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = 1'b0;

   // ---------------- per-bit logic ----------------
   genvar gi;
   generate
      for (gi = 0; gi < IO_NUM; gi++) begin : g_bit
         localparam int SL = gi / APB_WIDTH;   // slice holding this bit
         localparam int SB = gi % APB_WIDTH;   // bit position within slice
         logic [7:0] cfg;
         logic       word_hit, clr, rise, fall, flag_next;

         assign cfg      = cfg_reg[gi*8 +: 8];
         assign word_hit = wr_en && (32'(slice) == SL);
         assign cfg_next[gi*8 +: 8] =
            (wr_en && is_cfg && (cfg_idx == 5'(gi))) ? apb.PWDATA[7:0] : cfg;
         assign gpout_next[gi] = (word_hit && is_gpout) ? apb.PWDATA[SB] : gpout_reg[gi];
         assign clr  = word_hit && is_intr && apb.PWDATA[SB];
         assign rise = s2_reg[gi] & ~s3_reg[gi];
         assign fall = ~s2_reg[gi] & s3_reg[gi];

         // Level types simply track the synchronized pin, so a clear cannot
         // stick; edge types latch and a same-cycle set beats the clear.
         always_comb begin
            flag_next = 1'b0;
            if (cfg[3]) begin
               case (cfg[7:5])
                  3'd0:    flag_next = s2_reg[gi];
                  3'd1:    flag_next = ~s2_reg[gi];
                  3'd2:    flag_next = rise | (intr_reg[gi] & ~clr);
                  3'd3:    flag_next = fall | (intr_reg[gi] & ~clr);
                  3'd4:    flag_next = rise | fall | (intr_reg[gi] & ~clr);
                  default: flag_next = 1'b0;
               endcase
            end
         end
         assign intr_next[gi] = flag_next;

         assign GPIO_OUT[gi] = gpout_reg[gi] & cfg[0];
         assign GPIO_OE[gi]  = (OE_TYPE != 0) ? 1'b1 : cfg[2];
      end
   endgenerate

   // ---------------- state ----------------
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         cfg_reg   <= '0;
         gpout_reg <= '0;
         intr_reg  <= '0;
         s1_reg    <= '0;
         s2_reg    <= '0;
         s3_reg    <= '0;
      end else begin
         cfg_reg   <= cfg_next;
         gpout_reg <= gpout_next;
         intr_reg  <= intr_next;
         s1_reg    <= GPIO_IN;
         s2_reg    <= s1_reg;
         s3_reg    <= s2_reg;   // free-running, so config writes never fake an edge
      end
   end

   assign INT    = intr_reg;
   assign INT_OR = (INT_BUS != 0) ? |intr_reg : 1'b0;
endmodule

// File: tb/tb_core_gpio.sv
// tb_core_gpio: directed plus randomized APB/pin stimulus for core_gpio,
// compared against a behavioural model of the register map and interrupts.
module tb_core_gpio;
   localparam int IO = 8;

   logic          PCLK = 1'b0;
   logic          PRESETN;
   logic [IO-1:0] gpio_in, gpio_out, gpio_oe, int_vec;
   logic          int_or;

   core_gpio_if #(.APB_WIDTH(32)) apb ();

   core_gpio #(.IO_NUM(IO), .APB_WIDTH(32), .OE_TYPE(0), .INT_BUS(1)) dut (
      .PCLK     (PCLK),
      .PRESETN  (PRESETN),
      .apb      (apb),
      .GPIO_IN  (gpio_in),
      .GPIO_OUT (gpio_out),
      .GPIO_OE  (gpio_oe),
      .INT      (int_vec),
      .INT_OR   (int_or)
   );

   always #5 PCLK = ~PCLK;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model. m_pin[0] is the pin value sampled at the latest edge,
   // m_pin[1] the value software sees in GPIN, m_pin[2] the one before that.
   logic [7:0]    m_cfg [IO];
   logic [IO-1:0] m_gpout, m_intr;
   logic [IO-1:0] m_pin [3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < IO; i++) m_cfg[i] = 8'h00;
      m_gpout = '0;
      m_intr  = '0;
      for (int k = 0; k < 3; k++) m_pin[k] = '0;
   endtask

   function automatic logic [31:0] model_read(input logic [7:0] addr);
      if (addr[1:0] != 2'b00)                return 32'h0;
      if (addr < 8'h80)                      return (int'(addr) / 4 < IO) ? {24'h0, m_cfg[int'(addr) / 4]} : 32'h0;
      if (addr == 8'h80)                     return 32'(m_intr);
      if (addr == 8'h90)                     return 32'(m_pin[1]);
      if (addr == 8'hA0)                     return 32'(m_gpout);
      return 32'h0;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      logic [IO-1:0] clr, new_intr;
      logic          s2, s3, hit;
      logic [2:0]    ty;
      logic          wr;
      wr  = apb.PSEL && apb.PENABLE && apb.PWRITE;
      clr = '0;
      if (wr && apb.PADDR == 8'h80) clr = apb.PWDATA[IO-1:0];
      for (int i = 0; i < IO; i++) begin
         s2 = m_pin[1][i];
         s3 = m_pin[2][i];
         ty = m_cfg[i][7:5];
         new_intr[i] = 1'b0;
         if (m_cfg[i][3]) begin
            if (ty == 3'd0)      new_intr[i] = s2;
            else if (ty == 3'd1) new_intr[i] = !s2;
            else if (ty <= 3'd4) begin
               hit = (ty == 3'd2 && s2 && !s3) || (ty == 3'd3 && !s2 && s3) || (ty == 3'd4 && s2 != s3);
               new_intr[i] = hit || (m_intr[i] && !clr[i]);
            end
         end
      end
      m_intr = new_intr;
      if (wr && apb.PADDR[1:0] == 2'b00 && apb.PADDR < 8'h80 && int'(apb.PADDR) / 4 < IO)
         m_cfg[int'(apb.PADDR) / 4] = apb.PWDATA[7:0];
      if (wr && apb.PADDR == 8'hA0) m_gpout = apb.PWDATA[IO-1:0];
      m_pin[2] = m_pin[1];
      m_pin[1] = m_pin[0];
      m_pin[0] = gpio_in;
   endtask

   task automatic check_pins(input string tag);
      logic [IO-1:0] e_out, e_oe;
      for (int i = 0; i < IO; i++) begin
         e_out[i] = m_gpout[i] & m_cfg[i][0];
         e_oe[i]  = m_cfg[i][2];
      end
      check({tag, ".out"},    32'(gpio_out), 32'(e_out));
      check({tag, ".oe"},     32'(gpio_oe),  32'(e_oe));
      check({tag, ".int"},    32'(int_vec),  32'(m_intr));
      check({tag, ".int_or"}, 32'(int_or),   32'(|m_intr));
   endtask

   task automatic step();
      model_edge();
      @(posedge PCLK);
      #1;
      check_pins("step");
   endtask

   task automatic bus_idle();
      apb.PSEL    = 1'b0;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = 1'b0;
      apb.PADDR   = 8'h00;
      apb.PWDATA  = 32'h0;
   endtask

   task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
      apb.PSEL    = 1'b1;
      apb.PWRITE  = 1'b1;
      apb.PENABLE = 1'b0;
      apb.PADDR   = addr;
      apb.PWDATA  = data;
      step();
      apb.PENABLE = 1'b1;
      step();
      bus_idle();
      $display("wr addr=%02h data=%08h", addr, data);
   endtask

   task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
      apb.PSEL    = 1'b1;
      apb.PWRITE  = 1'b0;
      apb.PENABLE = 1'b0;
      apb.PADDR   = addr;
      step();
      apb.PENABLE = 1'b1;
      #1;
      data = apb.PRDATA;
      check("rd_data", data, model_read(addr));
      check("pready", 32'(apb.PREADY), 32'h1);
      check("pslverr", 32'(apb.PSLVERR), 32'h0);
      step();
      bus_idle();
      $display("rd addr=%02h data=%08h", addr, data);
   endtask

   logic [31:0] rd;
   logic [7:0]  a;

   initial begin
      bus_idle();
      gpio_in = '0;
      PRESETN = 1'b0;
      model_reset();
      #2;
      check_pins("reset");
      check("reset.prdata", apb.PRDATA, 32'h0);
      #10 PRESETN = 1'b1;   // released away from a clock edge
      @(posedge PCLK); #1;
      step();

      // reset values of the register map
      apb_read(8'h00, rd); check("cfg0_rst", rd, 32'h0);
      apb_read(8'h80, rd); check("intr_rst", rd, 32'h0);
      apb_read(8'h90, rd); check("gpin_rst", rd, 32'h0);
      apb_read(8'hA0, rd); check("gpout_rst", rd, 32'h0);

      // output enable / output value
      apb_write(8'h00, 32'h05);
      apb_write(8'hA0, 32'h1);
      check("out0_on", 32'(gpio_out[0]), 32'h1);
      check("oe0_on", 32'(gpio_oe[0]), 32'h1);
      apb_write(8'h00, 32'h04);
      check("out0_off", 32'(gpio_out[0]), 32'h0);
      check("oe0_still", 32'(gpio_oe[0]), 32'h1);

      // synchronizer latency on GPIN
      apb.PSEL = 1'b1; apb.PWRITE = 1'b0; apb.PADDR = 8'h90;
      gpio_in = 8'hA5;
      #1 check("gpin_e0", apb.PRDATA, 32'h0);
      step(); check("gpin_e1", apb.PRDATA, 32'h0);
      step(); check("gpin_e2", apb.PRDATA, 32'hA5);
      bus_idle();
      gpio_in = '0;
      repeat (3) step();

      // rising edge interrupt on bit 1
      apb_write(8'h04, 32'h48);
      gpio_in[1] = 1'b1;
      step(); step();
      check("rise_e2", 32'(int_vec[1]), 32'h0);
      step();
      check("rise_e3", 32'(int_vec[1]), 32'h1);
      check("rise_or", 32'(int_or), 32'h1);
      apb_write(8'h80, 32'h2);
      check("rise_clr", 32'(int_vec[1]), 32'h0);
      repeat (3) step();
      check("rise_hold", 32'(int_vec[1]), 32'h0);

      // edge arriving in the same cycle as the clear: set wins
      gpio_in[1] = 1'b0;
      repeat (4) step();
      check("fall_ignored", 32'(int_vec[1]), 32'h0);
      gpio_in[1] = 1'b1;
      step();
      apb_write(8'h80, 32'h2);   // commit edge is the 3rd edge after the change
      check("set_wins", 32'(int_vec[1]), 32'h1);
      apb_write(8'h80, 32'h2);
      check("clr_after", 32'(int_vec[1]), 32'h0);

      // level-high interrupt on bit 2
      apb_write(8'h08, 32'h08);
      gpio_in[2] = 1'b1;
      repeat (3) step();
      check("lvl_set", 32'(int_vec[2]), 32'h1);
      apb_write(8'h80, 32'h4);
      check("lvl_clr_noeff", 32'(int_vec[2]), 32'h1);
      step();
      check("lvl_hold", 32'(int_vec[2]), 32'h1);
      gpio_in[2] = 1'b0;
      repeat (3) step();
      check("lvl_drop", 32'(int_vec[2]), 32'h0);

      // out-of-range and unmapped accesses
      apb_write(8'h20, 32'hFF);
      apb_read(8'h20, rd); check("cfg8_zero", rd, 32'h0);
      apb_read(8'h84, rd); check("unmapped", rd, 32'h0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0, 1: begin gpio_in = IO'($urandom); step(); end
            2, 3, 4, 5, 6, 7, 8: begin
               case ($urandom_range(0, 5))
                  0, 1:    a = 8'(4 * $urandom_range(0, 9));
                  2:       a = 8'h80;
                  3:       a = 8'h90;
                  4:       a = 8'hA0;
                  default: a = 8'($urandom_range(0, 255));
               endcase
               if ($urandom_range(0, 1) == 1) apb_write(a, $urandom);
               else                           apb_read(a, rd);
            end
            default: step();
         endcase
      end

      // reset in the middle of a write access phase aborts it
      apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = 8'hA0; apb.PWDATA = 32'hFF;
      apb.PENABLE = 1'b1;
      #2 PRESETN = 1'b0;
      model_reset();
      #1 check_pins("midreset");
      @(posedge PCLK); #2;
      bus_idle();
      PRESETN = 1'b1;
      @(posedge PCLK); #1;
      check_pins("post_reset");
      apb_read(8'hA0, rd); check("gpout_aborted", rd, 32'h0);
      apb_read(8'h00, rd); check("cfg0_cleared", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
